// File: rtl/sine_pkg.sv
// Shared definitions for the sine requester and the engine control unit:
// FSM state encoding and default operand width / completion timeout.
package sine_pkg;

  localparam int DEFAULT_W       = 16;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    HOLD
  } state_t;

endpackage

// File: rtl/sine_wdog.sv
// Watchdog counter: cleared on demand, counts while enabled and saturates
// at LIMIT, flagging expiry so the requester can abandon a hung engine.
module sine_wdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0] r_count;

  assign o_expired = (r_count == CW'(LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/sine_requester.sv
// Handshake front end for the sine engine: accepts one angle, starts the
// engine, waits for completion (or times out) and holds the result downstream.
module sine_requester
  import sine_pkg::*;
#(
  parameter int W       = DEFAULT_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_x,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_s,
  output logic         res_err,
  output logic         eng_start,
  output logic [W-1:0] eng_x,
  input  logic         eng_ready,
  input  logic [W-1:0] eng_s,
  output logic         busy,
  output logic [7:0]   done_cnt
);

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_xReg;
  logic [W-1:0] r_resS;
  logic         r_resErr;
  logic [7:0]   r_doneCnt;

  logic w_accept;
  logic w_complete;
  logic w_timeout;
  logic w_release;
  logic w_wdogClear;
  logic w_wdogEnable;
  logic w_expired;

  sine_wdog #(
    .LIMIT(TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_wdogClear),
    .i_enable (w_wdogEnable),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // In WAIT_BUSY a high eng_ready is the engine's leftover Idle level, not completion.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (req_valid && eng_ready) w_next = ISSUE;
      ISSUE:     w_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (w_expired)       w_next = HOLD;
        else if (!eng_ready) w_next = WAIT_DONE;
      end
      WAIT_DONE: if (eng_ready || w_expired) w_next = HOLD;
      HOLD:      if (res_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (r_state == IDLE) && eng_ready;
    eng_start    = (r_state == ISSUE);
    res_valid    = (r_state == HOLD);
    busy         = (r_state != IDLE);
    w_wdogClear  = (r_state == ISSUE);
    w_wdogEnable = (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);
    w_accept     = (r_state == IDLE) && req_valid && eng_ready;
    w_complete   = (r_state == WAIT_DONE) && eng_ready;
    w_timeout    = w_expired &&
                   ((r_state == WAIT_BUSY) || ((r_state == WAIT_DONE) && !eng_ready));
    w_release    = (r_state == HOLD) && res_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_xReg    <= '0;
      r_resS    <= '0;
      r_resErr  <= 1'b0;
      r_doneCnt <= 8'd0;
    end else begin
      if (w_accept) r_xReg <= req_x;
      if (w_complete) begin
        r_resS   <= eng_s;
        r_resErr <= 1'b0;
      end else if (w_timeout) begin
        r_resS   <= '0;
        r_resErr <= 1'b1;
      end
      if (w_release) r_doneCnt <= r_doneCnt + 8'd1;
    end
  end

  assign eng_x    = r_xReg;
  assign res_s    = r_resS;
  assign res_err  = r_resErr;
  assign done_cnt = r_doneCnt;

endmodule

// File: tb/tb_sine_requester.sv
// Directed bench for sine_requester with a behavioural sine engine model
// (Idle -> Init -> Compute, result = operand ^ 16'hA5A5).
module tb_sine_requester;

  localparam int W       = 16;
  localparam int TIMEOUT = 255;
  localparam int COMPUTE = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_x = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_s;
  logic         res_err;
  logic         eng_start;
  logic [W-1:0] eng_x;
  logic         eng_ready;
  logic [W-1:0] eng_s = '0;
  logic         busy;
  logic [7:0]   done_cnt;

  int checks = 0;
  int failures = 0;

  // Engine model controls: stuck never finishes, staleReady keeps ready high in Init.
  int           engState = 0;
  int           engCnt = 0;
  logic [W-1:0] engX = '0;
  bit           engStuck = 0;
  bit           engKill = 0;
  bit           staleReady = 0;
  int           startCount = 0;

  sine_requester #(
    .W(W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x    (req_x),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_s    (res_s),
    .res_err  (res_err),
    .eng_start(eng_start),
    .eng_x    (eng_x),
    .eng_ready(eng_ready),
    .eng_s    (eng_s),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  assign eng_ready = (engState == 0) || ((engState == 1) && staleReady);

  always @(posedge clk) begin
    if (eng_start) startCount++;
    if (engKill) begin
      engState <= 0;
    end else begin
      case (engState)
        0: if (eng_start) begin
          engState <= 1;
          engX     <= eng_x;
        end
        1: if (!eng_start) begin
          engState <= 2;
          engCnt   <= COMPUTE;
        end
        2: if (!engStuck) begin
          if (engCnt == 1) begin
            engState <= 0;
            eng_s    <= engX ^ 16'hA5A5;
          end else begin
            engCnt <= engCnt - 1;
          end
        end
        default: engState <= 0;
      endcase
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendReq(input logic [W-1:0] x, output bit ok);
    req_x = x;
    req_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !req_ready; i++) tick();
    if (req_ready) begin
      ok = 1;
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic waitValid(input int limit, output int cycles, output bit ok);
    cycles = 0;
    ok = 0;
    while (cycles < limit && !ok) begin
      tick();
      cycles++;
      if (res_valid) ok = 1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(3);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++; if (res_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_res_err got=%b exp=0", res_err); end
    checks++; if (eng_start !== 1'b0) begin failures++; $display("[TB] FAIL reset_eng_start got=%b exp=0", eng_start); end
    checks++; if (res_s !== 16'h0000) begin failures++; $display("[TB] FAIL reset_res_s got=%h exp=0000", res_s); end
    checks++; if (eng_x !== 16'h0000) begin failures++; $display("[TB] FAIL reset_eng_x got=%h exp=0000", eng_x); end
    checks++; if (done_cnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_done_cnt got=%0d exp=0", done_cnt); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready got=%b exp=1", req_ready); end
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_single;
    bit ok;
    bit got;
    int cyc;
    int s0;
    s0 = startCount;
    sendReq(16'h1000, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL single_accept got=%b exp=1", ok); end
    checks++; if (eng_start !== 1'b1) begin failures++; $display("[TB] FAIL single_start got=%b exp=1", eng_start); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL single_req_ready got=%b exp=0", req_ready); end
    checks++; if (eng_x !== 16'h1000) begin failures++; $display("[TB] FAIL single_eng_x got=%h exp=1000", eng_x); end
    waitValid(40, cyc, got);
    checks++; if (!got || cyc != 15) begin failures++; $display("[TB] FAIL single_latency got=%0d exp=15 (valid=%b)", cyc, got); end
    checks++; if (res_s !== 16'hB5A5) begin failures++; $display("[TB] FAIL single_res_s got=%h exp=b5a5", res_s); end
    checks++; if (res_err !== 1'b0) begin failures++; $display("[TB] FAIL single_res_err got=%b exp=0", res_err); end
    checks++; if (startCount - s0 != 1) begin failures++; $display("[TB] FAIL single_start_count got=%0d exp=1", startCount - s0); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL single_release got=%b/%b exp=0/0", res_valid, busy); end
    checks++; if (done_cnt !== 8'd1) begin failures++; $display("[TB] FAIL single_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_hold_stall;
    bit ok;
    bit got;
    int cyc;
    int s0;
    sendReq(16'h2345, ok);
    waitValid(40, cyc, got);
    checks++; if (!got) begin failures++; $display("[TB] FAIL stall_valid got=0 exp=1"); end
    s0 = startCount;
    req_x = 16'h7777;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (res_valid !== 1'b1 || res_s !== 16'h86E0 || req_ready !== 1'b0 || eng_start !== 1'b0)
        begin failures++; $display("[TB] FAIL stall_hold cyc=%0d got v=%b s=%h rr=%b st=%b exp v=1 s=86e0 rr=0 st=0", i, res_valid, res_s, req_ready, eng_start); end
    end
    checks++; if (startCount != s0) begin failures++; $display("[TB] FAIL stall_extra_start got=%0d exp=0", startCount - s0); end
    checks++; if (eng_x !== 16'h2345) begin failures++; $display("[TB] FAIL stall_eng_x got=%h exp=2345", eng_x); end
    req_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (done_cnt !== 8'd2) begin failures++; $display("[TB] FAIL stall_done_cnt got=%0d exp=2", done_cnt); end
  endtask

  task automatic test_stale_ready;
    bit ok;
    bit got;
    int cyc;
    staleReady = 1;
    sendReq(16'h0F0F, ok);
    waitValid(40, cyc, got);
    checks++; if (!got || cyc != 15) begin failures++; $display("[TB] FAIL stale_latency got=%0d exp=15 (valid=%b)", cyc, got); end
    checks++; if (res_s !== 16'hAAAA) begin failures++; $display("[TB] FAIL stale_res_s got=%h exp=aaaa", res_s); end
    checks++; if (res_err !== 1'b0) begin failures++; $display("[TB] FAIL stale_res_err got=%b exp=0", res_err); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    staleReady = 0;
    checks++; if (done_cnt !== 8'd3) begin failures++; $display("[TB] FAIL stale_done_cnt got=%0d exp=3", done_cnt); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    sendReq(16'h5555, ok);
    tick(5);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL midrst_busy_before got=%b exp=1", busy); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || eng_start !== 1'b0) begin failures++; $display("[TB] FAIL midrst_ctrl got b=%b v=%b st=%b exp 0/0/0", busy, res_valid, eng_start); end
    checks++; if (res_s !== 16'h0000 || eng_x !== 16'h0000) begin failures++; $display("[TB] FAIL midrst_data got s=%h x=%h exp 0000/0000", res_s, eng_x); end
    checks++; if (done_cnt !== 8'd0) begin failures++; $display("[TB] FAIL midrst_done_cnt got=%0d exp=0", done_cnt); end
    tick();
    rst = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_after cyc=%0d got v=%b b=%b exp 0/0", i, res_valid, busy); end
    end
    res_ready = 1'b0;
    checks++; if (done_cnt !== 8'd0) begin failures++; $display("[TB] FAIL idle_res_ready_done got=%0d exp=0", done_cnt); end
  endtask

  task automatic test_timeout;
    bit ok;
    bit got;
    int cyc;
    engStuck = 1;
    sendReq(16'h1234, ok);
    waitValid(300, cyc, got);
    checks++; if (!got || cyc != TIMEOUT + 2) begin failures++; $display("[TB] FAIL timeout_latency got=%0d exp=%0d (valid=%b)", cyc, TIMEOUT + 2, got); end
    checks++; if (res_err !== 1'b1) begin failures++; $display("[TB] FAIL timeout_res_err got=%b exp=1", res_err); end
    checks++; if (res_s !== 16'h0000) begin failures++; $display("[TB] FAIL timeout_res_s got=%h exp=0000", res_s); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (done_cnt !== 8'd1) begin failures++; $display("[TB] FAIL timeout_done_cnt got=%0d exp=1", done_cnt); end
    req_valid = 1'b1;
    req_x = 16'h4321;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (req_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL engbusy_no_accept cyc=%0d got rr=%b b=%b exp 0/0", i, req_ready, busy); end
    end
    req_valid = 1'b0;
    engKill = 1;
    tick();
    engKill = 0;
    engStuck = 0;
    checks++; if (req_ready !== 1'b1 || eng_x !== 16'h1234) begin failures++; $display("[TB] FAIL engbusy_recover got rr=%b x=%h exp 1/1234", req_ready, eng_x); end
  endtask

  task automatic test_back_to_back;
    int acc;
    int cyc;
    int s0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    s0 = startCount;
    acc = 0;
    cyc = 0;
    res_ready = 1'b1;
    req_x = 16'h0000;
    req_valid = 1'b1;
    while (acc < 300 && cyc < 20000) begin
      if (req_ready) begin
        acc++;
        tick();
        req_x = req_x + 16'd1;
        if (acc == 300) req_valid = 1'b0;
      end else begin
        tick();
      end
      cyc++;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 50 && busy; i++) tick();
    res_ready = 1'b0;
    checks++; if (acc != 300) begin failures++; $display("[TB] FAIL b2b_accepted got=%0d exp=300", acc); end
    checks++; if (done_cnt !== 8'd44) begin failures++; $display("[TB] FAIL b2b_done_cnt got=%0d exp=44", done_cnt); end
    checks++; if (startCount - s0 != 300) begin failures++; $display("[TB] FAIL b2b_starts got=%0d exp=300", startCount - s0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold_stall();
    test_stale_ready();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sine_requester.md
SINE_REQUESTER -- requirements
Module: sine_requester

Interface
REQ-001 Parameter W, default 16, width of angle operand and sine result.
REQ-002 Parameter TIMEOUT, default 255, max cycles waited for engine completion.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  upstream angle request present.
REQ-006 req_ready  out  1  block accepts request this cycle.
REQ-007 req_x  in  W  angle operand.
REQ-008 res_valid  out  1  result held for downstream.
REQ-009 res_ready  in  1  downstream accepts result.
REQ-010 res_s  out  W  sine result.
REQ-011 res_err  out  1  result invalid, engine timed out; qualified by res_valid.
REQ-012 eng_start  out  1  start strobe to sine engine.
REQ-013 eng_x  out  W  operand to engine.
REQ-014 eng_ready  in  1  engine idle/done indication.
REQ-015 eng_s  in  W  engine accumulator output.
REQ-016 busy  out  1  transaction in progress (state != IDLE).
REQ-017 done_cnt  out  8  completed transactions, wraps 255->0.

Function
REQ-018 Engine contract: eng_ready=1 only in engine Idle; start=1 in Idle moves it to Init; it stays in Init while start=1, leaves on first cycle start=0; eng_ready returns to 1 at completion with eng_s valid.
REQ-019 FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD.
REQ-020 IDLE: req_ready=eng_ready; req_valid&&req_ready -> latch req_x into x_reg, go ISSUE.
REQ-021 ISSUE: eng_start=1 exactly one cycle -> WAIT_BUSY.
REQ-022 WAIT_BUSY: eng_ready=0 -> WAIT_DONE; eng_ready=1 ignored (stale Idle level) and never taken as completion.
REQ-023 WAIT_DONE: eng_ready=1 -> latch eng_s into res_s, res_err=0, go HOLD.
REQ-024 Timeout counter cleared on entry to ISSUE, increments in WAIT_BUSY and WAIT_DONE; reaching TIMEOUT -> res_s=0, res_err=1, go HOLD.
REQ-025 HOLD: res_valid=1; res_s/res_err stable until res_ready=1, then -> IDLE, done_cnt+1 (also on timeout).
REQ-026 eng_x=x_reg at all times; x_reg changes only on request acceptance.
REQ-027 Latency: acceptance to res_valid = engine compute cycles + 3; req_ready=0 in every state but IDLE.
REQ-028 req_valid in IDLE with eng_ready=0 (engine still busy after reset/timeout): no acceptance, stay IDLE.
REQ-029 res_ready without res_valid: no effect.

Reset
REQ-030 rst=0 asynchronously forces IDLE; eng_start, res_valid, res_err, busy=0; res_s, x_reg, timeout counter, done_cnt=0.
REQ-031 Reset mid-transaction discards the in-flight request and result; no res_valid pulse follows reset release.

Structure
REQ-032 Package sine_pkg holds state enum typedef and default W/TIMEOUT constants, shared with engine CU.
REQ-033 Timeout counter is sub-module sine_wdog (clear, enable, expired output); rest inline.

Verification
REQ-034 Engine model 12-cycle compute, req_x=16'h1000 -> eng_start one cycle, res_valid 15 cycles after acceptance, res_s=model value, res_err=0, done_cnt=1.
REQ-035 res_ready held 0 for 20 cycles in HOLD -> res_s stable, req_ready=0, no second eng_start.
REQ-036 Engine never reasserts eng_ready, TIMEOUT=255 -> res_valid with res_err=1, res_s=0 after 256 cycles in WAIT states.
REQ-037 Back-to-back 300 requests, res_ready=1 -> done_cnt wraps to 44, one eng_start per request.
REQ-038 rst=0 during WAIT_DONE -> immediate IDLE, outputs zero, no res_valid after release until new request.
